// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, port indices and default memory depth
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_DBG  = 1'b1;
    localparam int   DEF_DEPTH = 64;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-requester round-robin pick
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any,
    output logic gnt
);
    // on a tie the port that did not win last time is chosen
    always_comb begin
        any = req0 | req1;
        gnt = (req0 && req1) ? ~last_grant : (req1 ? PORT_DBG : PORT_CPU);
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sequencer sharing one data memory between CPU and debug ports
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);

    state_t            state;
    logic              sel;
    logic              last_grant;
    logic              any;
    logic              gnt;
    logic              p;
    logic              go;
    logic              we_p;
    logic [ADDR_W-1:0] addr_p;
    logic [DATA_W-1:0] wdata_p;
    logic              oor;
    logic              we_sel;

    rr_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .any        (any),
        .gnt        (gnt)
    );

    // next port to launch: arbiter pick from IDLE, the other port from RESP
    always_comb begin
        p       = (state == RESP) ? ~sel : gnt;
        go      = (state == RESP) ? (p ? req1 : req0) : any;
        we_p    = p ? we1 : we0;
        addr_p  = p ? addr1 : addr0;
        wdata_p = p ? wdata1 : wdata0;
        oor     = mem_addr >= LIM;
        we_sel  = sel ? we1 : we0;
    end

    // sequencer FSM; memory lines are loaded on entry to ACCESS so they are valid for that whole cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= PORT_CPU;
            last_grant <= PORT_DBG;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ACCESS: begin
                    state      <= RESP;
                    last_grant <= sel;
                    if (sel == PORT_DBG) begin
                        ack1 <= 1'b1;
                        err1 <= oor;
                        if (!we_sel) rdata1 <= oor ? '0 : mem_rdata;
                    end else begin
                        ack0 <= 1'b1;
                        err0 <= oor;
                        if (!we_sel) rdata0 <= oor ? '0 : mem_rdata;
                    end
                end
                IDLE, RESP: begin
                    if (go) begin
                        state     <= ACCESS;
                        sel       <= p;
                        mem_addr  <= addr_p;
                        mem_wdata <= wdata_p;
                        mem_we    <= we_p && (addr_p < LIM);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter with a behavioural memory
module tb_data_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          ack_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    logic [31:0] mem [64];
    exp_t        em;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: combinational read, write committed on the falling edge
    assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_we && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic push(input int p, input logic e, input logic [31:0] r);
        exp_t x;
        x.port = p;
        x.err = e;
        x.rdata = r;
        q.push_back(x);
    endtask

    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        if (p == 0) begin
            we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout port=%0d actual=0 required=1", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    // monitor: every ack pops the next expected response
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            ack_cyc.push_back(cyc);
            chk("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=ack0:%0b/ack1:%0b required=none", ack0, ack1);
            end else begin
                em = q.pop_front();
                chk("sb_port", ack1 ? 32'd1 : 32'd0, em.port);
                chk("sb_err", {31'b0, ack1 ? err1 : err0}, {31'b0, em.err});
                chk("sb_rdata", ack1 ? rdata1 : rdata0, em.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b;
        int w;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ack0", {31'b0, ack0}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_err0", {31'b0, err0}, 32'd0);

        push(0, 1'b0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("lat_ack0_cycle1", {31'b0, ack0}, 32'd0);
        @(posedge clk); #1;
        chk("lat_ack0_cycle2", {31'b0, ack0}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;

        w = we_cnt;
        push(0, 1'b0, 32'h0);
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF);
        chk("write5_we_cycles", we_cnt - w, 32'd1);
        w = we_cnt;
        push(0, 1'b0, 32'hDEADBEEF);
        txn(0, 1'b0, 32'd5, 32'h0);
        chk("read5_we_cycles", we_cnt - w, 32'd0);

        push(0, 1'b0, 32'hDEADBEEF);
        txn(0, 1'b1, 32'd2, 32'h22222222);
        push(1, 1'b0, 32'h0);
        txn(1, 1'b1, 32'd1, 32'h11111111);

        b = ack_cyc.size();
        push(0, 1'b0, 32'h11111111);
        push(1, 1'b0, 32'h22222222);
        push(0, 1'b0, 32'h11111111);
        fork
            begin
                txn(0, 1'b0, 32'd1, 32'h0);
                txn(0, 1'b0, 32'd1, 32'h0);
            end
            txn(1, 1'b0, 32'd2, 32'h0);
        join
        checks++;
        if (ack_cyc.size() < b + 3) begin
            errors++;
            $display("FAIL rr_ack_count actual=%0d required=%0d", ack_cyc.size() - b, 3);
        end else begin
            chk("rr_gap_0_1", ack_cyc[b+1] - ack_cyc[b], 32'd2);
            chk("rr_gap_1_2", ack_cyc[b+2] - ack_cyc[b+1], 32'd2);
        end

        w = we_cnt;
        push(1, 1'b1, 32'h22222222);
        txn(1, 1'b1, 32'd64, 32'hBADBAD00);
        chk("oor_write_we_cycles", we_cnt - w, 32'd0);
        push(1, 1'b1, 32'h0);
        txn(1, 1'b0, 32'd70, 32'h0);

        push(1, 1'b0, 32'h0);
        push(0, 1'b0, 32'h12345678);
        fork
            txn(1, 1'b1, 32'd3, 32'h12345678);
            begin
                @(posedge clk); #1;
                txn(0, 1'b0, 32'd3, 32'h0);
            end
        join

        we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hCAFEF00D; req0 = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_we_high", {31'b0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we_async", {31'b0, mem_we}, 32'd0);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_ack0", {31'b0, ack0}, 32'd0);
        rst_n = 1'b1;
        chk("abort_rdata0", rdata0, 32'd0);
        chk("abort_rdata1", rdata1, 32'd0);
        @(posedge clk); #1;

        push(0, 1'b0, 32'hDEADBEEF);
        push(1, 1'b0, 32'h12345678);
        fork
            txn(0, 1'b0, 32'd5, 32'h0);
            txn(1, 1'b0, 32'd3, 32'h0);
        join
        push(0, 1'b0, 32'h0);
        txn(0, 1'b0, 32'd7, 32'h0);

        repeat (5) @(negedge clk);
        chk("sb_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
